// File: rtl/main_deco_pkg.sv
// Shared RV32I decode constants and the control-word layout used by the main decoder.
package rv32iPkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       regWrite;
        logic [1:0] immSrc;
        logic       aluSrc;
        logic       memWrite;
        logic [1:0] resSrc;
        logic       branch;
        logic [1:0] aluOp;
        logic       jump;
        logic       illegal;
    } ctrlWord_t;

    localparam int        CTRL_W   = $bits(ctrlWord_t);
    localparam ctrlWord_t CTRL_NOP = '0;

endpackage

// File: rtl/main_deco_comb.sv
// Combinational opcode-to-control-word table; anything unrecognised (including X/Z)
// falls to the default branch and yields an all-zero word flagged illegal.
module mainDecoComb
    import rv32iPkg::*;
(
    input  logic [6:0]        op,
    output logic [CTRL_W-1:0] ctrl
);

    ctrlWord_t word;

    always_comb begin
        word = CTRL_NOP;
        case (op)
            OP_LOAD: begin
                word.regWrite = 1'b1;
                word.immSrc   = IMM_I;
                word.aluSrc   = 1'b1;
                word.resSrc   = RES_MEM;
                word.aluOp    = ALUOP_ADD;
            end
            OP_STORE: begin
                word.immSrc   = IMM_S;
                word.aluSrc   = 1'b1;
                word.memWrite = 1'b1;
                word.aluOp    = ALUOP_ADD;
            end
            OP_RTYPE: begin
                word.regWrite = 1'b1;
                word.resSrc   = RES_ALU;
                word.aluOp    = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                word.immSrc   = IMM_B;
                word.branch   = 1'b1;
                word.aluOp    = ALUOP_SUB;
            end
            OP_ITYPE: begin
                word.regWrite = 1'b1;
                word.immSrc   = IMM_I;
                word.aluSrc   = 1'b1;
                word.aluOp    = ALUOP_FUNCT;
            end
            OP_JAL: begin
                word.regWrite = 1'b1;
                word.immSrc   = IMM_J;
                word.resSrc   = RES_PC4;
                word.jump     = 1'b1;
            end
            OP_JALR: begin
                word.regWrite = 1'b1;
                word.immSrc   = IMM_I;
                word.aluSrc   = 1'b1;
                word.resSrc   = RES_PC4;
                word.jump     = 1'b1;
            end
            default: begin
                word.illegal  = 1'b1;
            end
        endcase
    end

    assign ctrl = word;

endmodule

// File: rtl/main_deco.sv
// RV32I main control decoder: registers the decoded control word so every output
// comes straight from a flop; reset forces the NOP word (illegal=0).
module main_deco
    import rv32iPkg::*;
(
    input  logic       clk,
    input  logic       rstN,
    input  logic [6:0] op,
    output logic       branch,
    output logic       jump,
    output logic [1:0] resSrc,
    output logic       memWrite,
    output logic       aluSrc,
    output logic [1:0] immSrc,
    output logic       regWrite,
    output logic [1:0] aluOp,
    output logic       illegal
);

    logic [CTRL_W-1:0] ctrlD;
    ctrlWord_t         ctrlQ;

    mainDecoComb uDecoComb (
        .op   (op),
        .ctrl (ctrlD)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ctrlQ <= CTRL_NOP;
        end else begin
            ctrlQ <= ctrlWord_t'(ctrlD);
        end
    end

    assign regWrite = ctrlQ.regWrite;
    assign immSrc   = ctrlQ.immSrc;
    assign aluSrc   = ctrlQ.aluSrc;
    assign memWrite = ctrlQ.memWrite;
    assign resSrc   = ctrlQ.resSrc;
    assign branch   = ctrlQ.branch;
    assign aluOp    = ctrlQ.aluOp;
    assign jump     = ctrlQ.jump;
    assign illegal  = ctrlQ.illegal;

endmodule

// File: tb/tb_main_deco.sv
// Bench for main_deco: directed vector table, async-reset sequences and random
// opcodes checked against a lookup model of the opcode/control-word table.
module tb_main_deco;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [6:0] op = 7'd0;
    logic       branch, jump, memWrite, aluSrc, regWrite, illegal;
    logic [1:0] resSrc, immSrc, aluOp;

    main_deco dut (
        .clk      (clk),
        .rstN     (rstN),
        .op       (op),
        .branch   (branch),
        .jump     (jump),
        .resSrc   (resSrc),
        .memWrite (memWrite),
        .aluSrc   (aluSrc),
        .immSrc   (immSrc),
        .regWrite (regWrite),
        .aluOp    (aluOp),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Word order: regWrite, immSrc, aluSrc, memWrite, resSrc, branch, aluOp, jump, illegal
    localparam logic [11:0] W_NOP    = 12'b0_00_0_0_00_0_00_0_0;
    localparam logic [11:0] W_LOAD   = 12'b1_00_1_0_01_0_00_0_0;
    localparam logic [11:0] W_STORE  = 12'b0_01_1_1_00_0_00_0_0;
    localparam logic [11:0] W_RTYPE  = 12'b1_00_0_0_00_0_10_0_0;
    localparam logic [11:0] W_BRANCH = 12'b0_10_0_0_00_1_01_0_0;
    localparam logic [11:0] W_ITYPE  = 12'b1_00_1_0_00_0_10_0_0;
    localparam logic [11:0] W_JAL    = 12'b1_11_0_0_10_0_00_1_0;
    localparam logic [11:0] W_JALR   = 12'b1_00_1_0_10_0_00_1_0;
    localparam logic [11:0] W_ILL    = 12'b0_00_0_0_00_0_00_0_1;

    typedef struct {
        int          opc;
        logic [11:0] word;
    } specRow_t;

    typedef struct {
        logic [6:0]  op;
        logic [11:0] exp;
        string       name;
    } vec_t;

    specRow_t spec[7];
    vec_t     vecs[14];

    int nCmp = 0;
    int nBad = 0;

    function automatic logic [11:0] dutWord();
        return {regWrite, immSrc, aluSrc, memWrite, resSrc, branch, aluOp, jump, illegal};
    endfunction

    function automatic logic [11:0] model(logic [6:0] o);
        if ($isunknown(o)) return W_ILL;
        foreach (spec[i]) begin
            if (spec[i].opc == int'(o)) return spec[i].word;
        end
        return W_ILL;
    endfunction

    task automatic check(string name, logic [11:0] exp);
        logic [11:0] got;
        got = dutWord();
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    task automatic edgeThenSample();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] prevExp;
    logic [11:0] e;

    initial begin
        spec[0] = '{3,   W_LOAD};
        spec[1] = '{35,  W_STORE};
        spec[2] = '{51,  W_RTYPE};
        spec[3] = '{99,  W_BRANCH};
        spec[4] = '{19,  W_ITYPE};
        spec[5] = '{111, W_JAL};
        spec[6] = '{103, W_JALR};

        vecs[0]  = '{7'd3,        W_LOAD,   "load"};
        vecs[1]  = '{7'd35,       W_STORE,  "store"};
        vecs[2]  = '{7'd99,       W_BRANCH, "branch"};
        vecs[3]  = '{7'd19,       W_ITYPE,  "itype"};
        vecs[4]  = '{7'd111,      W_JAL,    "jal"};
        vecs[5]  = '{7'd103,      W_JALR,   "jalr"};
        vecs[6]  = '{7'd51,       W_RTYPE,  "rtype"};
        vecs[7]  = '{7'd127,      W_ILL,    "op127"};
        vecs[8]  = '{7'd0,        W_ILL,    "op0"};
        vecs[9]  = '{7'bxxxxx00,  W_ILL,    "opX_a"};
        vecs[10] = '{7'bxx0xx10,  W_ILL,    "opX_b"};
        vecs[11] = '{7'd3,        W_LOAD,   "b2b_load"};
        vecs[12] = '{7'd35,       W_STORE,  "b2b_store"};
        vecs[13] = '{7'd83,       W_ILL,    "op83"};

        // Reset held with a legal opcode: outputs must stay at the NOP word.
        rstN = 1'b0;
        op   = 7'd51;
        #1;
        check("reset_initial", W_NOP);
        repeat (3) begin
            edgeThenSample();
            check("reset_hold", W_NOP);
        end
        rstN = 1'b1;
        #1;
        check("release_before_edge", W_NOP);
        edgeThenSample();
        check("first_decode_rtype", W_RTYPE);
        prevExp = W_RTYPE;

        // Directed table: output holds until the edge, then shows the new word.
        for (int i = 0; i < 14; i++) begin
            op = vecs[i].op;
            #1;
            check({vecs[i].name, "_hold"}, prevExp);
            edgeThenSample();
            check(vecs[i].name, vecs[i].exp);
            prevExp = vecs[i].exp;
        end

        // Async reset between edges with a store decoded.
        op = 7'd35;
        edgeThenSample();
        check("store_before_reset", W_STORE);
        #2;
        rstN = 1'b0;
        #1;
        check("async_reset_clear", W_NOP);
        op = 7'd51;
        edgeThenSample();
        check("async_reset_hold", W_NOP);
        rstN = 1'b1;
        #1;
        check("async_release_wait", W_NOP);
        edgeThenSample();
        check("after_release_rtype", W_RTYPE);
        prevExp = W_RTYPE;

        // Random opcodes, biased toward the supported set.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0)
                op = 7'(spec[$urandom_range(0, 6)].opc);
            else
                op = 7'($urandom_range(0, 127));
            e = model(op);
            #1;
            check("rand_hold", prevExp);
            edgeThenSample();
            check("rand_decode", e);
            prevExp = e;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
